// File: rtl/fpga_top_if.sv
// SPI pin bundle plus LED bank for the ADC reader top level.
interface fpga_top_if;
  logic       sclk;
  logic       mosi;
  logic       ncs;
  logic       miso;
  logic [7:0] led;

  modport master (output sclk, mosi, ncs, led, input miso);
  modport slave  (input sclk, mosi, ncs, led, output miso);
endinterface

// File: rtl/fpga_top.sv
// Free-running SPI master: reads a 16-bit word from an MCP3002-style ADC
// each frame and shows rx[9:2] on the LEDs.
module fpga_top #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned IDLE_CYC = 16,
  parameter logic [15:0] CMD      = 16'h6800
) (
  input  logic       clk,
  input  logic       reset,
  fpga_top_if.master spi
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TRAIL} state_e;

  localparam int unsigned CNT_MAX = (DIV > IDLE_CYC) ? DIV : IDLE_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   rx_q, rx_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          ncs_q, ncs_d;
  logic [7:0]    led_q, led_d;
  logic [3:0]    nxt_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ncs_q   <= ncs_d;
      led_q   <= led_d;
    end
  end

  // Every output is a register; miso only reaches rx_q at the sclk falling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ncs_d   = ncs_q;
    led_d   = led_q;
    nxt_bit = bit_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        if (cnt_q == IDLE_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = CMD[15];
          bit_d   = '0;
        end
      end
      LOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          sclk_d  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          rx_d   = {rx_q[14:0], spi.miso};
          if (bit_q != 4'd15) begin
            state_d = LOW;
            bit_d   = nxt_bit;
            mosi_d  = CMD[4'd15 - nxt_bit];
          end else begin
            state_d = TRAIL;
            mosi_d  = 1'b0;
          end
        end
      end
      TRAIL: begin
        if (cnt_q == DIV_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ncs_d   = 1'b1;
          led_d   = rx_q[9:2];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi.sclk = sclk_q;
  assign spi.mosi = mosi_q;
  assign spi.ncs  = ncs_q;
  assign spi.led  = led_q;

endmodule

// File: tb/tb_fpga_top.sv
// Bench for fpga_top: default build plus a DIV=2/IDLE_CYC=1 build, each with a behavioural ADC slave.
module tb_fpga_top;

  localparam logic [15:0] CMD = 16'h6800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  fpga_top_if ifa ();
  fpga_top_if ifb ();

  fpga_top #(.DIV(4), .IDLE_CYC(16), .CMD(CMD)) dut0 (.clk(clk), .reset(rst0), .spi(ifa.master));
  fpga_top #(.DIV(2), .IDLE_CYC(1),  .CMD(CMD)) dut1 (.clk(clk), .reset(rst1), .spi(ifb.master));

  logic [1:0] ncs_s, sclk_s, mosi_s, rst_s;
  logic [7:0] led_s [2];
  logic [1:0] miso_r = 2'b00;

  assign ncs_s    = {ifb.ncs, ifa.ncs};
  assign sclk_s   = {ifb.sclk, ifa.sclk};
  assign mosi_s   = {ifb.mosi, ifa.mosi};
  assign rst_s    = {rst1, rst0};
  assign led_s[0] = ifa.led;
  assign led_s[1] = ifb.led;
  assign ifa.miso = miso_r[0];
  assign ifb.miso = miso_r[1];

  // Slave words the initial block chooses, and per-frame observations.
  logic [15:0] tx_word [2] = '{16'h0000, 16'h0000};
  logic        prev_ncs [2] = '{1'b1, 1'b1};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        aborted [2] = '{1'b1, 1'b1};
  logic        led_moved [2] = '{1'b0, 1'b0};
  logic [7:0]  prev_led [2] = '{8'h00, 8'h00};
  int unsigned ncs_run [2] = '{0, 0};
  int unsigned hi_run [2] = '{0, 0};
  int unsigned lo_run [2] = '{0, 0};
  int unsigned rises [2] = '{0, 0};
  logic [15:0] mosi_cap [2];
  logic [15:0] rx_model [2];
  int unsigned hi_min [2], hi_max [2], lo_min [2], lo_max [2];
  int unsigned frames_done [2] = '{0, 0};
  int unsigned frame_len [2], idle_len [2], frame_rises [2];
  int unsigned f_hi_min [2], f_hi_max [2], f_lo_min [2], f_lo_max [2];
  logic [15:0] frame_mosi [2], frame_rx [2];
  logic [7:0]  led_at_end [2];
  logic        frame_led_moved [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_s[d]) aborted[d] = 1'b1;
      if (ncs_s[d] !== prev_ncs[d]) begin
        if (ncs_s[d] === 1'b1) begin
          if (!aborted[d]) begin
            if (lo_run[d] < lo_min[d]) lo_min[d] = lo_run[d];
            if (lo_run[d] > lo_max[d]) lo_max[d] = lo_run[d];
            frame_len[d]       = ncs_run[d];
            frame_rises[d]     = rises[d];
            frame_mosi[d]      = mosi_cap[d];
            frame_rx[d]        = rx_model[d];
            led_at_end[d]      = led_s[d];
            frame_led_moved[d] = led_moved[d];
            f_hi_min[d] = hi_min[d]; f_hi_max[d] = hi_max[d];
            f_lo_min[d] = lo_min[d]; f_lo_max[d] = lo_max[d];
            frames_done[d]++;
          end
        end else begin
          if (!aborted[d]) idle_len[d] = ncs_run[d];
          aborted[d] = 1'b0;
          rises[d] = 0; mosi_cap[d] = '0; rx_model[d] = '0;
          hi_min[d] = 9999; hi_max[d] = 0; lo_min[d] = 9999; lo_max[d] = 0;
          lo_run[d] = 0; hi_run[d] = 0; led_moved[d] = 1'b0;
        end
        ncs_run[d] = 1;
      end else begin
        ncs_run[d]++;
      end

      if (ncs_s[d] === 1'b0) begin
        if (led_s[d] !== prev_led[d]) led_moved[d] = 1'b1;
        if (sclk_s[d] === 1'b1 && prev_sclk[d] === 1'b0) begin
          rises[d]++;
          if (lo_run[d] < lo_min[d]) lo_min[d] = lo_run[d];
          if (lo_run[d] > lo_max[d]) lo_max[d] = lo_run[d];
          hi_run[d] = 1;
          mosi_cap[d] = {mosi_cap[d][14:0], mosi_s[d]};
          if (rises[d] <= 16) begin
            miso_r[d]   = tx_word[d][16 - rises[d]];
            rx_model[d] = {rx_model[d][14:0], tx_word[d][16 - rises[d]]};
          end
        end else if (sclk_s[d] === 1'b0 && prev_sclk[d] === 1'b1) begin
          if (hi_run[d] < hi_min[d]) hi_min[d] = hi_run[d];
          if (hi_run[d] > hi_max[d]) hi_max[d] = hi_run[d];
          lo_run[d] = 1;
        end else if (sclk_s[d] === 1'b1) begin
          hi_run[d]++;
        end else begin
          lo_run[d]++;
        end
      end
      prev_ncs[d]  = ncs_s[d];
      prev_sclk[d] = sclk_s[d];
      prev_led[d]  = led_s[d];
    end
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame(input int d, input int unsigned budget);
    int unsigned start, n;
    start = frames_done[d];
    n = 0;
    while (frames_done[d] == start && n < budget) begin
      step();
      n++;
    end
    check("frame_timeout", frames_done[d] - start, 1);
  endtask

  task automatic wait_rises(input int d, input int unsigned target, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!(ncs_s[d] === 1'b0 && rises[d] == target) && n < budget) begin
      step();
      n++;
    end
    check("rise_timeout", rises[d], target);
  endtask

  task automatic check_timing(input int d, input int unsigned div);
    check("frame_len", frame_len[d], 33 * div);
    check("frame_rises", frame_rises[d], 16);
    check("mosi_word", frame_mosi[d], CMD);
    check("sclk_hi", {f_hi_min[d][15:0], f_hi_max[d][15:0]}, {div[15:0], div[15:0]});
    check("sclk_lo", {f_lo_min[d][15:0], f_lo_max[d][15:0]}, {div[15:0], div[15:0]});
  endtask

  initial begin
    logic [15:0] pat, w;
    int unsigned n;

    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", {ifa.ncs, ifa.sclk, ifa.mosi, ifa.led}, {1'b1, 1'b0, 1'b0, 8'h00});
    end

    rst0 = 1'b0;
    n = 0;
    while (ifa.ncs !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("first_ncs_fall", n, 16);
    check("first_mosi", ifa.mosi, CMD[15]);

    // Slave bit k (1-based rise count) is 0 for k in {7,9,12}.
    pat = 16'hFFFF;
    for (int k = 1; k <= 16; k++)
      if (k == 7 || k == 9 || k == 12) pat[16 - k] = 1'b0;
    tx_word[0] = pat;
    wait_frame(0, 400);
    check("pattern_rx", frame_rx[0], 16'hFD6F);
    check("pattern_led", led_at_end[0], 8'h5B);
    check_timing(0, 4);

    tx_word[0] = 16'hFFFF;
    wait_frame(0, 400);
    check("idle_len", idle_len[0], 16);
    check("ones_led", led_at_end[0], 8'hFF);

    tx_word[0] = 16'h0000;
    wait_rises(0, 8, 400);
    check("led_hold_mid", ifa.led, 8'hFF);
    wait_frame(0, 400);
    check("zeros_led", led_at_end[0], 8'h00);
    check("led_quiet_in_frame", frame_led_moved[0], 1'b0);

    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      tx_word[0] = w;
      wait_frame(0, 400);
      check("rand_led", led_at_end[0], w[9:2]);
      check("rand_len", frame_len[0] + idle_len[0], 148);
    end

    tx_word[0] = 16'hFFFF;
    wait_frame(0, 400);
    check("pre_abort_led", led_at_end[0], 8'hFF);
    wait_rises(0, 8, 400);
    rst0 = 1'b1;
    step();
    check("abort_outputs", {ifa.ncs, ifa.sclk, ifa.mosi, ifa.led}, {1'b1, 1'b0, 1'b0, 8'h00});
    rst0 = 1'b0;
    n = 0;
    while (ifa.ncs !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("abort_restart", n, 16);
    check("abort_mosi", ifa.mosi, CMD[15]);
    w = 16'($urandom);
    tx_word[0] = w;
    wait_frame(0, 400);
    check("abort_led", led_at_end[0], w[9:2]);
    check_timing(0, 4);

    rst1 = 1'b0;
    n = 0;
    while (ifb.ncs !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("p_first_fall", n, 1);
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      tx_word[1] = w;
      wait_frame(1, 200);
      check("p_led", led_at_end[1], w[9:2]);
      check_timing(1, 2);
      if (i > 0) check("p_period", frame_len[1] + idle_len[1], 67);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
